// File: rtl/sm_reg_dumper_if.sv
// Register-dump port bundle: CPU debug readout (regAddr/regData), start/busy/done control, UART tx.
interface sm_reg_dumper_if;
  logic        start;
  logic [4:0]  regAddr;
  logic [31:0] regData;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    input  regData,
    output regAddr,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output regData,
    input  regAddr,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/sm_reg_dumper.sv
// Walks the CPU register file and streams 0xA5 + each 32-bit value (MSB first) as 8N1 UART bytes; tx is a flop output.
// No backpressure: start is ignored while busy. SM_REG_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module sm_reg_dumper #(
  parameter int BAUD_DIV  = 434,
  parameter int REG_COUNT = 32,
  parameter int SETTLE    = 3
) (
  input logic             clk,
  input logic             rst_n,
  sm_reg_dumper_if.master bus
);

  localparam logic [15:0] BAUD_LAST   = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [4:0]  ADDR_LAST   = 5'(REG_COUNT - 1);
  localparam logic [7:0]  SYNC_BYTE   = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SETTLE,
    ST_LOAD,
    ST_SEND
`ifdef SM_REG_DUMP_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [3:0]  settle_cnt;
  logic [4:0]  reg_addr;
  logic [31:0] word;
  logic [9:0]  shreg;
  logic        busy_q;
  logic        done_q;
`ifdef SM_REG_DUMP_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  logic       in_byte, baud_end, bit_end, byte_end, last_byte, last_reg, finish;
  logic [7:0] next_byte;

  assign bus.tx      = shreg[0];
  assign bus.regAddr = reg_addr;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_byte   = 1'b0;
    case (state)
      ST_SYNC, ST_SEND: in_byte = 1'b1;
`ifdef SM_REG_DUMP_CHECKSUM_EN
      ST_CSUM:          in_byte = 1'b1;
`endif
      default:          in_byte = 1'b0;
    endcase

    baud_end  = (baud_cnt == BAUD_LAST);
    bit_end   = baud_end && (bit_cnt == 4'd9);
    byte_end  = in_byte && bit_end;
    last_byte = (byte_cnt == 2'd3);
    last_reg  = (reg_addr == ADDR_LAST);

    // Byte following the one currently on the wire; index 3 wraps to the MSB and is never loaded.
    case (byte_cnt)
      2'd0:    next_byte = word[23:16];
      2'd1:    next_byte = word[15:8];
      2'd2:    next_byte = word[7:0];
      default: next_byte = word[31:24];
    endcase

    case (state)
      ST_IDLE:   if (bus.start) state_nxt = ST_SYNC;
      ST_SYNC:   if (byte_end) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = ST_SEND;
      ST_SEND: begin
        if (byte_end && last_byte) begin
          if (!last_reg)
            state_nxt = ST_SETTLE;
          else
`ifdef SM_REG_DUMP_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef SM_REG_DUMP_CHECKSUM_EN
      ST_CSUM:   if (byte_end) state_nxt = ST_IDLE;
`endif
      default:   state_nxt = ST_IDLE;
    endcase

    finish = byte_end && (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      settle_cnt <= '0;
      reg_addr   <= '0;
      word       <= '0;
      shreg      <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SM_REG_DUMP_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      done_q <= finish;
      if (finish) busy_q <= 1'b0;

      if (in_byte && !baud_end) baud_cnt <= baud_cnt + 16'd1;
      else                      baud_cnt <= '0;

      if (!in_byte || bit_end) bit_cnt <= '0;
      else if (baud_end)       bit_cnt <= bit_cnt + 4'd1;

      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 4'd1 : '0;

      // Shifting in ones leaves the line at the stop level once the frame drains.
      if (in_byte && baud_end && !bit_end) shreg <= {1'b1, shreg[9:1]};

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            shreg  <= {1'b1, SYNC_BYTE, 1'b0};
`ifdef SM_REG_DUMP_CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end
        ST_SYNC: begin
          if (byte_end) begin
            reg_addr <= '0;
            shreg    <= '1;
          end
        end
        ST_LOAD: begin
          word     <= bus.regData;
          byte_cnt <= '0;
          shreg    <= {1'b1, bus.regData[31:24], 1'b0};
`ifdef SM_REG_DUMP_CHECKSUM_EN
          csum     <= csum ^ bus.regData[31:24];
`endif
        end
        ST_SEND: begin
          if (byte_end) begin
            if (!last_byte) begin
              shreg    <= {1'b1, next_byte, 1'b0};
              byte_cnt <= byte_cnt + 2'd1;
`ifdef SM_REG_DUMP_CHECKSUM_EN
              csum     <= csum ^ next_byte;
`endif
            end else begin
              if (!last_reg) reg_addr <= reg_addr + 5'd1;
`ifdef SM_REG_DUMP_CHECKSUM_EN
              shreg <= last_reg ? {1'b1, csum, 1'b0} : '1;
`else
              shreg <= '1;
`endif
            end
          end
        end
`ifdef SM_REG_DUMP_CHECKSUM_EN
        ST_CSUM: if (byte_end) shreg <= '1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sm_reg_dumper.md
# sm_reg_dumper

Debug register-dump initiator for the CPU's register readout port. On a start request it walks the register file by driving `regAddr`, samples `regData` after a fixed settle time, and streams each 32-bit value out as 8N1 UART bytes on a single `tx` pin. It sits beside the CPU in the top level and replaces manual switch-driven register inspection with a host-readable dump.

## Interface
- `BAUD_DIV`, 434: clock cycles per UART bit; legal range 2..65535.
- `REG_COUNT`, 32: registers dumped, addresses 0..REG_COUNT-1; legal range 1..32.
- `SETTLE`, 3: cycles between the `regAddr` change and the `regData` sample; legal range 1..15. The default covers the 2-stage input filter plus 1 cycle of margin.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: a 1-cycle pulse that requests a dump; sampled only in IDLE.
- `regAddr` out 5: register address driven to the CPU debug port.
- `regData` in 32: register value returned by the CPU.
- `tx` out 1: UART serial output; idles high.
- `busy` out 1: high from the cycle after an accepted `start` until the final stop bit ends.
- `done` out 1: 1-cycle pulse on the cycle after the final stop bit ends.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `regAddr`=0, FSM in IDLE, all counters 0.
- States and transitions:
  - IDLE: on `start`=1, go to SYNC.
  - SYNC: send sync byte 0xA5. After it completes, set `regAddr`=0 and go to SETTLE.
  - SETTLE: wait SETTLE cycles, then go to LOAD.
  - LOAD: for 1 cycle, latch `regData` into a 32-bit word register, then go to SEND.
  - SEND: transmit 4 bytes, most-significant byte first.
    - After the 4th byte, if `regAddr`==REG_COUNT-1, go to CSUM when the checksum is compiled in, otherwise to IDLE.
    - Otherwise increment `regAddr` and go back to SETTLE.
  - CSUM: send the checksum byte, then go to IDLE.
- Byte framing:
  - 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
  - Each bit holds for exactly BAUD_DIV cycles.
  - Bytes are sent back-to-back with no idle gap, except for the SETTLE+1 cycles spent between registers, during which `tx`=1.
- `regAddr` is stable throughout SETTLE, LOAD and SEND. It keeps its last value after the dump until the next dump rewrites it to 0 at the end of SYNC.
- A `start` pulse while `busy` is ignored. It is not queued.
- Asserting `rst_n` low mid-dump forces `tx`=1 at once, which truncates the frame. The host must resync on 0xA5.
- Width rules:
  - Bit counter is 4 bits, byte counter 2 bits, settle counter 4 bits, baud counter 16 bits.
  - `regAddr` comparisons use REG_COUNT-1 truncated to 5 bits.

## Timing
- `tx` goes low, as the start bit of 0xA5, on the cycle after `start` is sampled high in IDLE. `busy` rises on the same cycle.
- Each byte lasts 10·BAUD_DIV cycles.
- Total dump length in cycles, without checksum: 10·BAUD_DIV·(1+4·REG_COUNT) + REG_COUNT·(SETTLE+1).
- The checksum adds 10·BAUD_DIV cycles.
- `busy` falls on the same cycle that `done` pulses.
- The earliest new `start` is accepted on the `done` cycle.

## Configuration
- `SM_REG_DUMP_CHECKSUM_EN` defined:
  - A running XOR of every byte sent after 0xA5 is kept, cleared on entry to SYNC.
  - The CSUM state sends it as the last byte.
- Not defined: CSUM and the XOR register are absent. The frame ends after the last data byte.

## Test plan
All scenarios use BAUD_DIV=4, REG_COUNT=2, SETTLE=3, and a behavioural register file where reg0=0x00000000 and reg1=0x12345678.
- Reset with `start` held low → `tx`=1, `busy`=0, `regAddr`=0 for 200 cycles.
- `start` pulse → the decoded byte stream is A5 00 00 00 00 12 34 56 78.
  - Every bit is exactly 4 cycles wide.
  - `done` pulses once.
  - Frame length is 10·4·9+2·4 = 368 cycles from the first start bit to `done`.
- `SM_REG_DUMP_CHECKSUM_EN` defined with the same stimulus → the stream ends with extra byte 0x08 (12^34^56^78), and length is 408 cycles.
- A second `start` pulse at cycle 100 of a dump → ignored. Exactly one frame is sent and `done` pulses once.
- `regData` changes to 0xFFFFFFFF during SEND of reg1 → the transmitted bytes are still 12 34 56 78.
- `rst_n` driven low during the 3rd byte → `tx`=1 and `busy`=0 immediately. After release, a new `start` yields a full correct frame beginning A5.
